// File: rtl/afifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read sides.
// Functions work on a zero-extended fixed-width container, so any pointer up to PTR_MAXW bits can use them.
package afifo_pkg;

  localparam int PTR_MAXW = 16;

  typedef logic [PTR_MAXW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = 1; i < PTR_MAXW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // The write pointer is a full lap ahead when it equals the read pointer
  // with its two most significant Gray bits inverted (w = pointer width).
  function automatic logic gray_full(input ptr_t wgray, input ptr_t rgray, input int w);
    ptr_t flip;
    flip = ptr_t'(3) << (w - 2);
    return wgray == (rgray ^ flip);
  endfunction

endpackage

// File: rtl/afifo_wptr_full_if.sv
// Producer-side write port of the async FIFO.
// Handshake: wr_en is the request and ~full is the ready; a word is written on
// every clk edge where wr_fire (= wr_en & ~full) is high. Requests while full are dropped.
interface afifo_wptr_full_if #(
  parameter int AW = 4
);

  logic          wr_en;
  logic          wr_fire;
  logic [AW-1:0] waddr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wcount;
  logic          wr_ovf;

  modport master (
    output wr_en,
    input  wr_fire, waddr, full, almost_full, wcount, wr_ovf
  );

  modport slave (
    input  wr_en,
    output wr_fire, waddr, full, almost_full, wcount, wr_ovf
  );

endinterface

// File: rtl/afifo_gray_cnt.sv
// Enable-driven binary + Gray pointer register, shared by the write and read sides.
// bin_next/gray_next are the combinational next values, used for registered flag compares.
module afifo_gray_cnt
  import afifo_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en,
  output logic [W-1:0] bin,
  output logic [W-1:0] gray,
  output logic [W-1:0] bin_next,
  output logic [W-1:0] gray_next
);

  assign bin_next  = bin + W'(en);
  assign gray_next = W'(bin2gray(ptr_t'(bin_next)));

  always_ff @(posedge clk) begin
    if (srst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/afifo_wptr_full.sv
// Write-domain pointer and flag logic of the async FIFO.
// Flags are computed from the next write pointer against the synchronised read pointer.
module afifo_wptr_full
  import afifo_pkg::*;
#(
  parameter int AW       = 4,
  parameter int AFULL_TH = 2**AW - 1
) (
  input  logic              clk,
  input  logic              srst,
  afifo_wptr_full_if.slave  wif,
  input  logic [AW:0]       rptr_gray_sync,
  output logic [AW:0]       wptr_gray
);

  localparam logic [AW:0] AFULL_V = (AW+1)'(AFULL_TH);

  logic [AW:0] wbin;
  logic [AW:0] wbin_next;
  logic [AW:0] wgray_next;
  logic [AW:0] rbin_s;
  logic [AW:0] fill_next;
  logic        full_next;

  assign wif.wr_fire = wif.wr_en & ~wif.full;
  assign wif.waddr   = wbin[AW-1:0];

  afifo_gray_cnt #(
    .W (AW + 1)
  ) u_wptr (
    .clk       (clk),
    .srst      (srst),
    .en        (wif.wr_fire),
    .bin       (wbin),
    .gray      (wptr_gray),
    .bin_next  (wbin_next),
    .gray_next (wgray_next)
  );

  // The synchronised read pointer lags the real one, so the fill level can
  // only be overestimated: full may linger but never drops early.
  assign rbin_s    = (AW+1)'(gray2bin(ptr_t'(rptr_gray_sync)));
  assign fill_next = wbin_next - rbin_s;
  assign full_next = gray_full(ptr_t'(wgray_next), ptr_t'(rptr_gray_sync), AW + 1);

  always_ff @(posedge clk) begin
    if (srst) begin
      wif.full        <= 1'b0;
      wif.almost_full <= 1'b0;
      wif.wcount      <= '0;
      wif.wr_ovf      <= 1'b0;
    end else begin
      wif.full        <= full_next;
      wif.almost_full <= (fill_next >= AFULL_V);
      wif.wcount      <= fill_next;
      wif.wr_ovf      <= wif.wr_en & wif.full;
    end
  end

endmodule

// File: tb/tb_afifo_wptr_full.sv
// Scoreboard bench for afifo_wptr_full (AW=2, AFULL_TH=3): directed scenarios then
// random writes/read-pointer advances, checked against an unwrapped-counter model.
module tb_afifo_wptr_full;

  localparam int AW       = 2;
  localparam int AFULL_TH = 3;
  localparam int DEPTH    = 2**AW;

  typedef struct packed {
    logic        fire;
    logic [1:0]  waddr;
    logic [2:0]  gray;
    logic        full;
    logic        af;
    logic [2:0]  cnt;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        srst;
  logic [AW:0] rptr_gray_sync;
  logic [AW:0] wptr_gray;

  afifo_wptr_full_if #(.AW(AW)) wif ();

  afifo_wptr_full #(
    .AW       (AW),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clk            (clk),
    .srst           (srst),
    .wif            (wif.slave),
    .rptr_gray_sync (rptr_gray_sync),
    .wptr_gray      (wptr_gray)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: writes and reads as unwrapped counts
  int   w_abs  = 0;
  int   r_cur  = 0;
  logic full_m = 1'b0;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [2:0] gray3(input int v);
    logic [2:0] b;
    b = 3'(v % 8);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // driver: one clock cycle of stimulus; r_i is the read count seen this cycle
  task automatic step(input logic rst_i, input logic we, input int r_i);
    exp_t e;
    int   fill;
    @(posedge clk);
    #1;
    srst           = rst_i;
    wif.wr_en      = we;
    rptr_gray_sync = gray3(r_i);
    e.fire = we && !full_m;
    if (rst_i) begin
      w_abs  = 0;
      r_cur  = 0;
      full_m = 1'b0;
      e.full = 1'b0;
      e.af   = 1'b0;
      e.cnt  = '0;
      e.ovf  = 1'b0;
    end else begin
      r_cur  = r_i;
      w_abs  = w_abs + (e.fire ? 1 : 0);
      fill   = w_abs - r_i;
      e.full = (fill == DEPTH);
      e.af   = (fill >= AFULL_TH);
      e.cnt  = 3'(fill);
      e.ovf  = we && full_m;
      full_m = e.full;
    end
    e.gray  = gray3(w_abs);
    e.waddr = 2'(w_abs % DEPTH);
    exp_q.push_back(e);
  endtask

  // monitor: wr_fire checked in its own cycle, registered outputs one edge later
  initial begin
    exp_t pend;
    exp_t cur;
    logic pend_v;
    pend_v = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_v) begin
        chk("wptr_gray",   8'(wptr_gray),       8'(pend.gray));
        chk("waddr",       8'(wif.waddr),       8'(pend.waddr));
        chk("full",        8'(wif.full),        8'(pend.full));
        chk("almost_full", 8'(wif.almost_full), 8'(pend.af));
        chk("wcount",      8'(wif.wcount),      8'(pend.cnt));
        chk("wr_ovf",      8'(wif.wr_ovf),      8'(pend.ovf));
      end
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("wr_fire", 8'(wif.wr_fire), 8'(cur.fire));
        pend   = cur;
        pend_v = 1'b1;
      end else begin
        pend_v = 1'b0;
      end
    end
  end

  // stimulus
  initial begin
    int rnew;
    srst           = 1'b1;
    wif.wr_en      = 1'b0;
    rptr_gray_sync = '0;
    repeat (2) @(posedge clk);

    // reset beats a simultaneous write
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 0);

    // fill to full, then overflow attempt
    repeat (4) step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);

    // read pointer advance releases full; next write refills
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 1);

    // wrap with the read pointer trailing
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, w_abs - 1);

    // reset mid-fill, then restart from address 0
    step(1'b1, 1'b1, r_cur);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rnew = r_cur + $urandom_range(0, w_abs - r_cur);
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rnew);
    end

    step(1'b0, 1'b0, r_cur);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
